// File: rtl/rtc_pkg.sv
// Shared types and constants for the DS1307-class RTC time keeper.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_DECODE,
    ST_DONE
  } state_t;

  localparam logic [7:0]  RegSeconds   = 8'h00;
  localparam int unsigned ClockHaltBit = 7;
  localparam int unsigned Mode12hBit   = 6;

  localparam logic [7:0] MaxSeconds = 8'd59;
  localparam logic [7:0] MaxMinutes = 8'd59;
  localparam logic [7:0] MaxHours   = 8'd23;

  function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/rtc_bcd_codec.sv
// Combinational 8-bit binary<->BCD conversion with a nibble range flag.
module rtc_bcd_codec (
  input  logic [7:0] i_bin,
  output logic [7:0] o_bcd,
  input  logic [7:0] i_bcd,
  output logic [7:0] o_bin,
  output logic       o_nibbles_ok
);

  always_comb begin
    o_bcd        = {4'(i_bin / 8'd10), 4'(i_bin % 8'd10)};
    o_bin        = ({4'b0, i_bcd[7:4]} * 8'd10) + {4'b0, i_bcd[3:0]};
    o_nibbles_ok = (i_bcd[7:4] <= 4'd9) && (i_bcd[3:0] <= 4'd9);
  end

endmodule

// File: rtl/rtc_time_keeper.sv
// Polls a DS1307-class RTC through the I2C master handshake, decodes the BCD
// time, and writes a new time on request.
module rtc_time_keeper
  import rtc_pkg::*;
#(
  parameter int unsigned ClockFrequency = 1000000,
  parameter int unsigned PollPeriodMs   = 1000,
  parameter logic [6:0]  RtcAddress     = 7'h68,
  parameter int unsigned MaxRetries     = 3,
  parameter int unsigned BusyTimeoutMs  = 5,
  parameter int unsigned MaxBytesToSend = 16,
  parameter int unsigned MaxBytesToRead = 16
) (
  input  logic                                reset,
  input  logic                                clock,
  input  logic                                setRequest,
  input  logic [4:0]                          setHours,
  input  logic [5:0]                          setMinutes,
  input  logic [5:0]                          setSeconds,
  output logic                                i2cStart,
  output logic [6:0]                          i2cAddress,
  output logic [$clog2(MaxBytesToSend):0]     i2cNrOfBytesToSend,
  output logic [MaxBytesToSend-1:0][7:0]      i2cBytesToSend,
  output logic [$clog2(MaxBytesToRead):0]     i2cNrOfBytesToRead,
  input  logic [MaxBytesToRead-1:0][7:0]      i2cBytesRead,
  input  logic                                i2cReady,
  input  logic                                i2cClockStretchTimeoutReached,
  input  logic                                i2cNoAcknowledge,
  output logic [4:0]                          hours,
  output logic [5:0]                          minutes,
  output logic [5:0]                          seconds,
  output logic                                timeValid,
  output logic                                error,
  output logic                                busy,
  output logic                                setDone
);

  localparam int unsigned CyclesPerMs = ClockFrequency / 1000;
  localparam int unsigned PollCycles  = CyclesPerMs * PollPeriodMs;
  localparam int unsigned BusyCycles  = CyclesPerMs * BusyTimeoutMs;
  localparam int unsigned PollW       = $clog2(PollCycles + 1);
  localparam int unsigned BusyW       = $clog2(BusyCycles + 1);
  localparam int unsigned RetryW      = $clog2(MaxRetries + 2);
  localparam int unsigned SendW       = $clog2(MaxBytesToSend) + 1;
  localparam int unsigned ReadW       = $clog2(MaxBytesToRead) + 1;

  state_t            r_state;
  logic [PollW-1:0]  r_poll_cnt;
  logic              r_poll_due;
  logic              r_set_pending;
  logic [7:0]        r_set_h;
  logic [7:0]        r_set_m;
  logic [7:0]        r_set_s;
  logic              r_is_write;
  logic [RetryW-1:0] r_retry;
  logic [BusyW-1:0]  r_busy_cnt;

  logic [7:0] w_set_s_bcd, w_set_m_bcd, w_set_h_bcd;
  logic [7:0] w_rd_s_bin, w_rd_m_bin, w_rd_h_bin;
  logic       w_rd_s_ok, w_rd_m_ok, w_rd_h_ok;
  logic       w_decode_ok;
  logic       w_fail;
  logic       w_drop;
  logic       w_clear_txn;
  logic       w_unused;

  rtc_bcd_codec u_sec (
    .i_bin        (r_set_s),
    .o_bcd        (w_set_s_bcd),
    .i_bcd        ({1'b0, i2cBytesRead[2][6:0]}),
    .o_bin        (w_rd_s_bin),
    .o_nibbles_ok (w_rd_s_ok)
  );

  rtc_bcd_codec u_min (
    .i_bin        (r_set_m),
    .o_bcd        (w_set_m_bcd),
    .i_bcd        (i2cBytesRead[1]),
    .o_bin        (w_rd_m_bin),
    .o_nibbles_ok (w_rd_m_ok)
  );

  rtc_bcd_codec u_hr (
    .i_bin        (r_set_h),
    .o_bcd        (w_set_h_bcd),
    .i_bcd        ({2'b00, i2cBytesRead[0][5:0]}),
    .o_bin        (w_rd_h_bin),
    .o_nibbles_ok (w_rd_h_ok)
  );

  assign i2cAddress = RtcAddress;

  assign w_decode_ok = w_rd_s_ok && w_rd_m_ok && w_rd_h_ok
                    && !i2cBytesRead[0][Mode12hBit]
                    && (w_rd_s_bin <= MaxSeconds)
                    && (w_rd_m_bin <= MaxMinutes)
                    && (w_rd_h_bin <= MaxHours);

  // All failure sources funnel through one signal so retry/drop is handled once.
  assign w_fail = ((r_state == ST_WAIT_BUSY) && i2cReady && (r_busy_cnt == BusyW'(BusyCycles - 1)))
               || ((r_state == ST_WAIT_DONE) && i2cReady
                   && (i2cNoAcknowledge || i2cClockStretchTimeoutReached))
               || ((r_state == ST_DECODE) && !w_decode_ok);
  assign w_drop      = w_fail && (r_retry >= RetryW'(MaxRetries));
  assign w_clear_txn = (r_state == ST_DONE) || w_drop;

  assign w_unused = ^{i2cBytesRead[MaxBytesToRead-1:3], i2cBytesRead[0][7:6], i2cBytesRead[2][7],
                      w_set_s_bcd[7], w_set_h_bcd[7:6]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state            <= ST_IDLE;
      r_poll_cnt         <= '0;
      r_poll_due         <= 1'b0;
      r_set_pending      <= 1'b0;
      r_set_h            <= '0;
      r_set_m            <= '0;
      r_set_s            <= '0;
      r_is_write         <= 1'b0;
      r_retry            <= '0;
      r_busy_cnt         <= '0;
      i2cStart           <= 1'b0;
      i2cNrOfBytesToSend <= '0;
      i2cBytesToSend     <= '0;
      i2cNrOfBytesToRead <= '0;
      hours              <= '0;
      minutes            <= '0;
      seconds            <= '0;
      timeValid          <= 1'b0;
      error              <= 1'b0;
      busy               <= 1'b0;
      setDone            <= 1'b0;
    end else begin
      i2cStart <= 1'b0;
      setDone  <= 1'b0;

      // A fresh expiry wins over a same-cycle clear so no poll is lost.
      if (r_poll_cnt == '0) begin
        r_poll_cnt <= PollW'(PollCycles - 1);
        r_poll_due <= 1'b1;
      end else begin
        r_poll_cnt <= r_poll_cnt - PollW'(1);
        if (w_clear_txn && !r_is_write) r_poll_due <= 1'b0;
      end

      if (setRequest) begin
        r_set_pending <= 1'b1;
        r_set_h       <= clamp({3'b0, setHours}, MaxHours);
        r_set_m       <= clamp({2'b0, setMinutes}, MaxMinutes);
        r_set_s       <= clamp({2'b0, setSeconds}, MaxSeconds);
      end else if (w_clear_txn && r_is_write) begin
        r_set_pending <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_set_pending) begin
            r_is_write <= 1'b1;
            busy       <= 1'b1;
            r_state    <= ST_ISSUE;
          end else if (r_poll_due) begin
            r_is_write <= 1'b0;
            busy       <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          i2cBytesToSend <= '0;
          if (r_is_write) begin
            i2cNrOfBytesToSend <= SendW'(4);
            i2cNrOfBytesToRead <= '0;
            i2cBytesToSend[3]  <= RegSeconds;
            i2cBytesToSend[2]  <= {1'b0, w_set_s_bcd[6:0]};
            i2cBytesToSend[1]  <= w_set_m_bcd;
            i2cBytesToSend[0]  <= {2'b00, w_set_h_bcd[5:0]};
          end else begin
            i2cNrOfBytesToSend <= SendW'(1);
            i2cNrOfBytesToRead <= ReadW'(3);
            i2cBytesToSend[0]  <= RegSeconds;
          end
          i2cStart   <= 1'b1;
          r_busy_cnt <= '0;
          r_state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!i2cReady) r_state    <= ST_WAIT_DONE;
          else           r_busy_cnt <= r_busy_cnt + BusyW'(1);
        end
        ST_WAIT_DONE: begin
          if (i2cReady && !i2cNoAcknowledge && !i2cClockStretchTimeoutReached)
            r_state <= r_is_write ? ST_DONE : ST_DECODE;
        end
        ST_DECODE: begin
          if (w_decode_ok) begin
            seconds   <= w_rd_s_bin[5:0];
            minutes   <= w_rd_m_bin[5:0];
            hours     <= w_rd_h_bin[4:0];
            timeValid <= 1'b1;
            error     <= 1'b0;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_retry <= '0;
          busy    <= 1'b0;
          setDone <= r_is_write;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_fail) begin
        if (w_drop) begin
          error   <= 1'b1;
          r_retry <= '0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end else begin
          r_retry <= r_retry + RetryW'(1);
          r_state <= ST_ISSUE;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_time_keeper.sv
// Scoreboard bench for rtc_time_keeper with a behavioural I2C master model.
module tb_rtc_time_keeper;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             setRequest = 1'b0;
  logic [4:0]       setHours = '0;
  logic [5:0]       setMinutes = '0;
  logic [5:0]       setSeconds = '0;
  logic             i2cStart;
  logic [6:0]       i2cAddress;
  logic [4:0]       i2cNrOfBytesToSend;
  logic [15:0][7:0] i2cBytesToSend;
  logic [4:0]       i2cNrOfBytesToRead;
  logic [15:0][7:0] i2cBytesRead = '0;
  logic             i2cReady = 1'b1;
  logic             i2cClockStretchTimeoutReached = 1'b0;
  logic             i2cNoAcknowledge = 1'b0;
  logic [4:0]       hours;
  logic [5:0]       minutes;
  logic [5:0]       seconds;
  logic             timeValid, error, busy, setDone;

  always #5 clock = ~clock;

  rtc_time_keeper #(
    .ClockFrequency (10000),
    .PollPeriodMs   (20),
    .RtcAddress     (7'h68),
    .MaxRetries     (3),
    .BusyTimeoutMs  (5),
    .MaxBytesToSend (16),
    .MaxBytesToRead (16)
  ) dut (
    .reset                         (reset),
    .clock                         (clock),
    .setRequest                    (setRequest),
    .setHours                      (setHours),
    .setMinutes                    (setMinutes),
    .setSeconds                    (setSeconds),
    .i2cStart                      (i2cStart),
    .i2cAddress                    (i2cAddress),
    .i2cNrOfBytesToSend            (i2cNrOfBytesToSend),
    .i2cBytesToSend                (i2cBytesToSend),
    .i2cNrOfBytesToRead            (i2cNrOfBytesToRead),
    .i2cBytesRead                  (i2cBytesRead),
    .i2cReady                      (i2cReady),
    .i2cClockStretchTimeoutReached (i2cClockStretchTimeoutReached),
    .i2cNoAcknowledge              (i2cNoAcknowledge),
    .hours                         (hours),
    .minutes                       (minutes),
    .seconds                       (seconds),
    .timeValid                     (timeValid),
    .error                         (error),
    .busy                          (busy),
    .setDone                       (setDone)
  );

  typedef struct {
    logic [4:0]  ns;
    logic [4:0]  nr;
    logic [31:0] b;
  } start_t;

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       tv;
    logic       er;
    logic       sd;
  } end_t;

  typedef struct {
    bit         stuck;
    bit         nack;
    logic [7:0] sec;
    logic [7:0] mn;
    logic [7:0] hr;
  } resp_t;

  start_t      exp_start[$];
  end_t        exp_end[$];
  resp_t       resp_q[$];
  int unsigned st_times[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Master model: ready drops a few cycles after start, returns after a busy period.
  resp_t cur;
  int    m_st = 0;
  int    m_cnt = 0;
  always @(negedge clock) begin
    if (reset) begin
      m_st = 0;
      i2cReady = 1'b1;
      i2cNoAcknowledge = 1'b0;
    end else begin
      case (m_st)
        0: if (i2cStart) begin
          if (resp_q.size() != 0) cur = resp_q.pop_front();
          else cur = '{stuck: 1'b0, nack: 1'b0, sec: 8'h00, mn: 8'h00, hr: 8'h00};
          if (!cur.stuck) begin m_st = 1; m_cnt = 3; end
        end
        1: if (m_cnt == 0) begin
          i2cReady = 1'b0; i2cNoAcknowledge = 1'b0; m_st = 2; m_cnt = 6;
        end else m_cnt--;
        2: if (m_cnt == 0) begin
          i2cBytesRead[2] = cur.sec;
          i2cBytesRead[1] = cur.mn;
          i2cBytesRead[0] = cur.hr;
          i2cNoAcknowledge = cur.nack;
          i2cReady = 1'b1;
          m_st = 0;
        end else m_cnt--;
        default: m_st = 0;
      endcase
    end
  end

  // Monitor: checks bus contents on each start and outputs at each transaction end.
  logic        prev_busy = 1'b0;
  start_t      es;
  end_t        ee;
  logic [31:0] gb;
  always @(negedge clock) begin
    if (reset) prev_busy = 1'b0;
    else begin
      if (i2cStart) begin
        st_times.push_back(cyc);
        checks++;
        gb = {i2cBytesToSend[3], i2cBytesToSend[2], i2cBytesToSend[1], i2cBytesToSend[0]};
        if (exp_start.size() == 0) begin
          errors++;
          $display("FAIL start_unexpected: got start at cycle %0d, required none", cyc);
        end else begin
          es = exp_start.pop_front();
          if (i2cNrOfBytesToSend != es.ns || i2cNrOfBytesToRead != es.nr || gb != es.b
              || i2cAddress != 7'h68 || (i2cBytesToSend >> 32) != '0) begin
            errors++;
            $display("FAIL start_bus: got ns=%0d nr=%0d bytes=%h addr=%h, required ns=%0d nr=%0d bytes=%h addr=68",
                     i2cNrOfBytesToSend, i2cNrOfBytesToRead, i2cBytesToSend, i2cAddress, es.ns, es.nr, es.b);
          end
        end
      end
      if (prev_busy && !busy) begin
        checks++;
        if (exp_end.size() == 0) begin
          errors++;
          $display("FAIL end_unexpected: got transaction end at cycle %0d, required none", cyc);
        end else begin
          ee = exp_end.pop_front();
          if (hours != ee.h || minutes != ee.m || seconds != ee.s || timeValid != ee.tv
              || error != ee.er || setDone != ee.sd) begin
            errors++;
            $display("FAIL end_state: got %0d:%0d:%0d tv=%0d err=%0d sd=%0d, required %0d:%0d:%0d tv=%0d err=%0d sd=%0d",
                     hours, minutes, seconds, timeValid, error, setDone,
                     ee.h, ee.m, ee.s, ee.tv, ee.er, ee.sd);
          end
        end
      end
      prev_busy = busy;
    end
  end

  task automatic push_resp(input bit stuck, input bit nack, input logic [7:0] s, input logic [7:0] m,
                           input logic [7:0] h);
    resp_q.push_back('{stuck: stuck, nack: nack, sec: s, mn: m, hr: h});
  endtask

  task automatic push_read_start();
    exp_start.push_back('{ns: 5'd1, nr: 5'd3, b: 32'h0000_0000});
  endtask

  task automatic push_write_start(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    exp_start.push_back('{ns: 5'd4, nr: 5'd0, b: {8'h00, s, m, h}});
  endtask

  task automatic push_end(input int h, input int m, input int s, input bit tv, input bit er, input bit sd);
    exp_end.push_back('{h: 5'(h), m: 6'(m), s: 6'(s), tv: tv, er: er, sd: sd});
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (exp_start.size() == 0 && exp_end.size() == 0) break;
      @(negedge clock);
    end
    checks++;
    if (exp_start.size() != 0 || exp_end.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d starts and %0d ends outstanding, required 0 and 0",
               name, exp_start.size(), exp_end.size());
      exp_start.delete();
      exp_end.delete();
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (i2cStart || i2cNrOfBytesToSend != '0 || i2cBytesToSend != '0 || i2cNrOfBytesToRead != '0
        || hours != '0 || minutes != '0 || seconds != '0 || timeValid || error || busy || setDone
        || i2cAddress != 7'h68) begin
      errors++;
      $display("FAIL %s: got start=%0d ns=%0d nr=%0d %0d:%0d:%0d tv=%0d err=%0d busy=%0d sd=%0d addr=%h, required all 0 addr=68",
               name, i2cStart, i2cNrOfBytesToSend, i2cNrOfBytesToRead, hours, minutes, seconds,
               timeValid, error, busy, setDone, i2cAddress);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_zero("reset_state");

    // First read right after reset.
    push_resp(0, 0, 8'h45, 8'h30, 8'h12);
    push_read_start();
    push_end(12, 30, 45, 1, 0, 0);
    reset = 1'b0;
    wait_drain(300, "first_read");

    // Clock-halt bit masked; 12h-mode hours rejected and retried.
    push_resp(0, 0, 8'hC7, 8'h31, 8'h12);
    push_read_start();
    push_end(12, 31, 47, 1, 0, 0);
    push_resp(0, 0, 8'h00, 8'h00, 8'h52);
    push_resp(0, 0, 8'h08, 8'h15, 8'h09);
    push_read_start();
    push_read_start();
    push_end(9, 15, 8, 1, 0, 0);
    wait_drain(1000, "ch_mask_and_mode12_retry");

    // Set-time write, then a clamped write.
    push_resp(0, 0, 8'h00, 8'h00, 8'h00);
    push_write_start(8'h58, 8'h59, 8'h23);
    push_end(9, 15, 8, 1, 0, 1);
    @(negedge clock);
    setHours = 5'd23; setMinutes = 6'd59; setSeconds = 6'd58; setRequest = 1'b1;
    @(negedge clock);
    setRequest = 1'b0;
    wait_drain(100, "write_23_59_58");

    push_resp(0, 0, 8'h00, 8'h00, 8'h00);
    push_write_start(8'h59, 8'h59, 8'h23);
    push_end(9, 15, 8, 1, 0, 1);
    setHours = 5'd31; setMinutes = 6'd63; setSeconds = 6'd60; setRequest = 1'b1;
    @(negedge clock);
    setRequest = 1'b0;
    wait_drain(100, "write_clamped");

    // Four NACKed attempts then error; next good read clears it.
    repeat (4) begin
      push_resp(0, 1, 8'h00, 8'h00, 8'h00);
      push_read_start();
    end
    push_end(9, 15, 8, 1, 1, 0);
    push_resp(0, 0, 8'h10, 8'h20, 8'h21);
    push_read_start();
    push_end(21, 20, 10, 1, 0, 0);
    wait_drain(1000, "nack_retries_error");

    // Set request coincides with the first poll after reset: write then read.
    reset = 1'b1;
    @(negedge clock);
    check_zero("reset_again");
    push_resp(0, 0, 8'h00, 8'h00, 8'h00);
    push_resp(0, 0, 8'h33, 8'h44, 8'h05);
    push_write_start(8'h03, 8'h02, 8'h01);
    push_end(0, 0, 0, 0, 0, 1);
    push_read_start();
    push_end(5, 44, 33, 1, 0, 0);
    st_times.delete();
    setHours = 5'd1; setMinutes = 6'd2; setSeconds = 6'd3; setRequest = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    setRequest = 1'b0;
    wait_drain(200, "write_before_read");
    checks++;
    if (st_times.size() != 2 || (st_times[1] - st_times[0]) > 30) begin
      errors++;
      $display("FAIL read_follows_write: got %0d starts, gap %0d, required 2 starts, gap <= 30",
               st_times.size(), (st_times.size() == 2) ? (st_times[1] - st_times[0]) : 0);
    end

    // Master never drops ready: busy timeout, then retry succeeds.
    st_times.delete();
    push_resp(1, 0, 8'h00, 8'h00, 8'h00);
    push_resp(0, 0, 8'h50, 8'h40, 8'h03);
    push_read_start();
    push_read_start();
    push_end(3, 40, 50, 1, 0, 0);
    wait_drain(600, "busy_timeout_retry");
    checks++;
    if (st_times.size() != 2 || (st_times[1] - st_times[0]) < 50 || (st_times[1] - st_times[0]) > 60) begin
      errors++;
      $display("FAIL busy_timeout_gap: got %0d starts, gap %0d, required 2 starts, gap 50..60",
               st_times.size(), (st_times.size() == 2) ? (st_times[1] - st_times[0]) : 0);
    end

    // Reset while waiting for the master to finish.
    push_resp(0, 0, 8'h11, 8'h22, 8'h03);
    push_read_start();
    for (int i = 0; i < 400; i++) begin
      if (exp_start.size() == 0) break;
      @(negedge clock);
    end
    for (int i = 0; i < 20; i++) begin
      if (!i2cReady) break;
      @(negedge clock);
    end
    checks++;
    if (exp_start.size() != 0 || i2cReady) begin
      errors++;
      $display("FAIL reach_wait_done: got starts_outstanding=%0d ready=%0d, required 0 and 0",
               exp_start.size(), i2cReady);
      exp_start.delete();
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_zero("reset_in_wait_done");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (i2cStart || busy) begin
        errors++;
        $display("FAIL start_during_reset: got start=%0d busy=%0d, required 0 and 0", i2cStart, busy);
      end
    end
    resp_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: got simulation still running at time %0t, required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/rtc_time_keeper.md
Name: rtc_time_keeper

Overview:
- Upstream controller for the I2C master in the clock design. Periodically reads seconds/minutes/hours from a DS1307-class RTC at 7'h68, validates and decodes BCD to binary, and presents the time to the display logic.
- Also accepts a set-time request and writes the new time to the RTC.
- Talks to the master only through its start/ready/parameter-bus handshake.

Parameters:
- ClockFrequency, 1000000, system clock in Hz; must equal the master's value.
- PollPeriodMs, 1000, interval between time reads.
- RtcAddress, 7'h68, 7-bit RTC slave address.
- MaxRetries, 3, retries after a failed transaction before flagging an error.
- BusyTimeoutMs, 5, max wait for the master to drop ready after start.
- MaxBytesToSend, 16; MaxBytesToRead, 16: must match the master.

Ports:
- reset  in  1  asynchronous, active-high
- clock  in  1  system clock
- setRequest  in  1  one-cycle pulse: write setHours/setMinutes/setSeconds to the RTC
- setHours  in  5  binary 0..23
- setMinutes  in  6  binary 0..59
- setSeconds  in  6  binary 0..59
- i2cStart  out  1  start pulse to the master
- i2cAddress  out  7  always RtcAddress
- i2cNrOfBytesToSend  out  $clog2(MaxBytesToSend)+1
- i2cBytesToSend  out  MaxBytesToSend x 8
- i2cNrOfBytesToRead  out  $clog2(MaxBytesToRead)+1
- i2cBytesRead  in  MaxBytesToRead x 8
- i2cReady  in  1
- i2cClockStretchTimeoutReached  in  1
- i2cNoAcknowledge  in  1
- hours  out  5; minutes  out  6; seconds  out  6  last valid time, binary
- timeValid  out  1  high once a read has decoded correctly
- error  out  1  high after MaxRetries+1 consecutive failures
- busy  out  1  transaction in progress
- setDone  out  1  one-cycle pulse after a successful write

Behaviour:
- Reset: all outputs 0 (i2cAddress = RtcAddress). State = IDLE. Poll counter preloaded as expired, so the first read starts right after reset. setPending = 0. Retry count = 0.
- Reset mid-transaction: aborts immediately to reset values. Master is reset by the same signal.
- Byte order: master sends bytesToSend[n-1] first, down to [0]. Received bytes land highest index first.
- Read transaction: nrOfBytesToSend = 1, bytesToSend[0] = 8'h00, nrOfBytesToRead = 3. Then seconds = bytesRead[2], minutes = bytesRead[1], hours = bytesRead[0].
- Write transaction: nrOfBytesToSend = 4, nrOfBytesToRead = 0.
  - [3] = 8'h00, [2] = BCD seconds with bit7 = 0 (clock running), [1] = BCD minutes, [0] = BCD hours with bit6 = 0 (24h mode).
  - Unused bytes are driven to 0.
- Poll timer: counts ClockFrequency/1000*PollPeriodMs cycles. Free-running; raises pollDue, which is held until served.
- States:
  - IDLE: if setPending, take the write; else if pollDue, take the read; else stay. A write wins over a simultaneous read. The read stays due.
  - ISSUE: load the parameter bus, assert i2cStart for exactly 1 cycle, then go to WAIT_BUSY. Parameter bus is held stable until DONE.
  - WAIT_BUSY: wait for i2cReady = 0. The master only reacts on its 1 ms tick. If BusyTimeoutMs elapses, count it as a failure.
  - WAIT_DONE: wait for i2cReady = 1. Then, if i2cNoAcknowledge or i2cClockStretchTimeoutReached, count a failure; else go to DECODE.
  - DECODE: read only; 1 cycle.
    - Seconds: mask bit7. Hours: require bit6 = 0, use bits 5:0.
    - Check every nibble ≤ 9 and sec ≤ 59, min ≤ 59, hr ≤ 23.
    - Pass: update outputs, timeValid = 1, error = 0. Fail: count a failure.
  - DONE: clear retry count, release busy, clear pollDue or setPending. A write pulses setDone. Return to IDLE.
- Failure handling: increment the retry count and re-enter ISSUE with the same transaction.
  - When the count exceeds MaxRetries, set error, drop the transaction, clear the count and go to IDLE.
  - A failed read keeps the old time and timeValid. error clears only on a later success.
- setRequest in any state latches setPending and captures the set values; a later request overwrites them. Out-of-range set values are clamped to their maximum.
- busy = 1 from ISSUE through DONE.

Decomposition:
- Package rtc_pkg: state enum, RTC register offsets (seconds 8'h00), ClockHalt bit 7, Mode12h bit 6, limits 59/59/23.
- Sub-module rtc_bcd_codec (combinational):
  - bin->BCD and BCD->bin for 8-bit fields;
  - a nibble-valid flag.

Test Plan:
- Reset, master model returns 8'h45,8'h30,8'h12 (sec,min,hr) -> after first read: seconds = 45, minutes = 30, hours = 12, timeValid = 1, error = 0.
- Seconds byte 8'hC5 (CH set) -> seconds = 45 (bit7 masked). Hours 8'h52 (bit6 set) -> read failure, retry.
- setRequest with 23:59:58 -> bytesToSend[3:0] = 00,58,59,23; nrOfBytesToSend = 4; nrOfBytesToRead = 0; setDone after the master's ready.
- noAcknowledge on every transaction, MaxRetries = 3 -> exactly 4 start pulses, then error = 1 and the previous time is held; the next good read clears error.
- setRequest in the same cycle that pollDue is raised -> write runs first, read follows immediately.
- Master never drops ready -> BusyTimeoutMs failure, retried. Reset asserted in WAIT_DONE -> all outputs 0 next cycle and i2cStart stays 0.
